// File: rtl/if_load_ctrl.sv
// Boot loader for the IF stage: packs a byte stream into 32-bit words, writes them via WE/W_Ins/bout/newPC, then releases the core.
// Optional trailing checksum byte: define IF_LOAD_CHKSUM_EN.
module if_load_ctrl #(
  parameter int IMEM_WORDS = 64,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [7:0]  LEN,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic        IF_RST,
  output logic        IF_WE,
  output logic [31:0] IF_W_INS,
  output logic [1:0]  IF_BOUT,
  output logic [31:0] IF_NEWPC,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        CORE_RUN
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RECV, S_WRITE, S_STEP, S_FIN, S_RUN
`ifdef IF_LOAD_CHKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_bcnt;
  logic [7:0]  r_wcnt, r_len;
  logic [31:0] r_addr, r_pack;
  logic [7:0]  r_sum;

  logic        w_acc, w_start_win, w_len_ok, w_start_ok, w_start_bad, w_chk_bad;
  logic [31:0] w_pack_nxt;

  logic        w_rdy_d, w_ifrst_d, w_we_d, w_busy_d, w_done_d, w_err_d, w_run_d;
  logic [1:0]  w_bout_d;
  logic [31:0] w_ins_d, w_npc_d;

  assign w_acc       = RX_VALID & RX_READY;
  assign w_start_win = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_len_ok    = (LEN != 8'd0) && (32'(LEN) <= 32'(IMEM_WORDS));
  assign w_start_ok  = START & w_start_win & w_len_ok;
  assign w_start_bad = START & w_start_win & ~w_len_ok;
  assign w_pack_nxt  = BIG_ENDIAN ? {r_pack[23:0], RX_DATA} : {RX_DATA, r_pack[31:8]};

`ifdef IF_LOAD_CHKSUM_EN
  assign w_chk_bad = (r_state == S_CHK) && w_acc && (RX_DATA != r_sum);
`else
  assign w_chk_bad = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN: if (w_start_ok) w_next = S_CLR;
      S_CLR:   w_next = S_RECV;
      S_RECV:  if (w_acc && r_bcnt == 2'd3) w_next = S_WRITE;
      S_WRITE: w_next = S_STEP;
      S_STEP: begin
        if (r_wcnt == r_len) begin
`ifdef IF_LOAD_CHKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_FIN;
`endif
        end else begin
          w_next = S_RECV;
        end
      end
`ifdef IF_LOAD_CHKSUM_EN
      S_CHK: if (w_acc) w_next = w_chk_bad ? S_IDLE : S_FIN;
`endif
      S_FIN:   w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output lines up with its state.
  always_comb begin
    w_rdy_d   = 1'b0;
    w_ifrst_d = 1'b0;
    w_we_d    = 1'b0;
    w_bout_d  = 2'b00;
    w_busy_d  = 1'b0;
    w_done_d  = 1'b0;
    w_run_d   = 1'b0;
    w_ins_d   = IF_W_INS;
    w_npc_d   = IF_NEWPC;
    w_err_d   = ERR;
    case (w_next)
      S_IDLE:  w_ifrst_d = 1'b1;
      S_CLR:   begin w_ifrst_d = 1'b1; w_busy_d = 1'b1; end
      S_RECV:  begin w_rdy_d = 1'b1; w_busy_d = 1'b1; end
      S_WRITE: begin w_we_d = 1'b1; w_busy_d = 1'b1; w_ins_d = w_pack_nxt; end
      S_STEP:  begin w_bout_d = 2'b01; w_busy_d = 1'b1; w_npc_d = r_addr + 32'd4; end
`ifdef IF_LOAD_CHKSUM_EN
      S_CHK:   begin w_rdy_d = 1'b1; w_busy_d = 1'b1; end
`endif
      S_FIN:   begin w_ifrst_d = 1'b1; w_done_d = 1'b1; end
      S_RUN:   w_run_d = 1'b1;
      default: w_ifrst_d = 1'b1;
    endcase
    if (w_start_ok)                    w_err_d = 1'b0;
    else if (w_start_bad || w_chk_bad) w_err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      RX_READY <= 1'b0;
      IF_RST   <= 1'b1;
      IF_WE    <= 1'b0;
      IF_W_INS <= 32'd0;
      IF_BOUT  <= 2'b00;
      IF_NEWPC <= 32'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      CORE_RUN <= 1'b0;
    end else begin
      r_state  <= w_next;
      RX_READY <= w_rdy_d;
      IF_RST   <= w_ifrst_d;
      IF_WE    <= w_we_d;
      IF_W_INS <= w_ins_d;
      IF_BOUT  <= w_bout_d;
      IF_NEWPC <= w_npc_d;
      BUSY     <= w_busy_d;
      DONE     <= w_done_d;
      ERR      <= w_err_d;
      CORE_RUN <= w_run_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bcnt <= 2'd0;
      r_wcnt <= 8'd0;
      r_len  <= 8'd0;
      r_addr <= 32'd0;
      r_pack <= 32'd0;
      r_sum  <= 8'd0;
    end else begin
      if (w_start_ok) r_len <= LEN;
      case (r_state)
        S_CLR: begin
          r_addr <= 32'd0;
          r_wcnt <= 8'd0;
          r_bcnt <= 2'd0;
          r_sum  <= 8'd0;
        end
        S_RECV: if (w_acc) begin
          r_pack <= w_pack_nxt;
          r_bcnt <= r_bcnt + 2'd1;
          r_sum  <= r_sum + RX_DATA;
        end
        S_WRITE: r_wcnt <= r_wcnt + 8'd1;
        S_STEP:  r_addr <= r_addr + 32'd4;
        default: ;
      endcase
    end
  end

endmodule
